// File: rtl/inst_fetch_arbiter.sv
// rtl/inst_fetch_arbiter.sv - IF/DBG arbiter in front of the combinational instruction ROM
//
// Purpose:
//   Shares one combinational instruction ROM between the fetch stage (IF) and
//   a debug/trace read port (DBG). IF has priority. A saturating starvation
//   counter lets DBG preempt IF after MAX_WAIT consecutive denied cycles.
//   The selected ROM word is registered, so each winner sees its data one
//   cycle after the grant.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous reset, active-low
//   if_req     in   IF fetch request (level)
//   if_addr    in   IF byte address
//   if_inst    out  registered IF instruction
//   if_valid   out  if_inst valid this cycle
//   stall_req  out  IF requesting while DBG holds the ROM (combinational)
//   dbg_req    in   DBG read request, held until dbg_ack
//   dbg_addr   in   DBG byte address, stable while dbg_req is high
//   dbg_inst   out  registered DBG read data
//   dbg_ack    out  one-cycle completion pulse
//   dbg_err    out  qualifies dbg_ack: misaligned address, no ROM access
//   rom_ce     out  ROM chip enable
//   rom_addr   out  ROM address
//   rom_inst   in   ROM data (combinational from rom_addr)

module inst_fetch_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = 32,
    parameter int INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [INST_W-1:0] if_inst,
    output logic              if_valid,
    output logic              stall_req,

    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [INST_W-1:0] dbg_inst,
    output logic              dbg_ack,
    output logic              dbg_err,

    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst
);

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    // MAX_WAIT = 0 would give a zero-width counter; keep one bit so the
    // compare below is always true and DBG always wins.
    localparam int              WCW   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0]  MAX_W = WCW'(MAX_WAIT);

    logic [INST_W-1:0] r_if_inst;
    logic              r_if_valid;
    logic [INST_W-1:0] r_dbg_inst;
    logic              r_dbg_ack;
    logic              r_dbg_err;
    logic [WCW-1:0]    r_wait_cnt;

    logic              w_dbg_pend;
    logic              w_dbg_aligned;
    logic              w_dbg_elig;
    logic              w_dbg_misal;
    logic              w_wait_full;
    logic              w_dbg_grant;
    logic              w_if_grant;

    // Every request term is qualified with rst so that no grant, ROM access
    // or stall can appear while the block is held in reset.
    always_comb begin
        // DBG is blocked in its own ack cycle: one outstanding access only.
        w_dbg_pend    = rst & dbg_req & ~r_dbg_ack;
        w_dbg_aligned = (dbg_addr[1:0] == 2'b00);
        w_dbg_elig    = w_dbg_pend & w_dbg_aligned;
        // A misaligned request is answered with an error without touching
        // the ROM, so it never competes with IF.
        w_dbg_misal   = w_dbg_pend & ~w_dbg_aligned;
        w_wait_full   = (r_wait_cnt >= MAX_W);
        w_dbg_grant   = w_dbg_elig & (~if_req | w_wait_full);
        w_if_grant    = rst & if_req & ~w_dbg_grant;
    end

    always_comb begin
        rom_ce   = CHIP_DISABLE;
        rom_addr = '0;
        if (w_dbg_grant) begin
            rom_ce   = CHIP_ENABLE;
            rom_addr = dbg_addr;
        end else if (w_if_grant) begin
            rom_ce   = CHIP_ENABLE;
            rom_addr = if_addr;
        end
    end

    assign stall_req = if_req & w_dbg_grant;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_if_inst  <= '0;
            r_if_valid <= 1'b0;
            r_dbg_inst <= '0;
            r_dbg_ack  <= 1'b0;
            r_dbg_err  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_if_valid <= w_if_grant;
            if (w_if_grant) begin
                r_if_inst <= rom_inst;
            end

            r_dbg_ack <= w_dbg_grant | w_dbg_misal;
            r_dbg_err <= w_dbg_misal;
            if (w_dbg_grant) begin
                r_dbg_inst <= rom_inst;
            end else if (w_dbg_misal) begin
                r_dbg_inst <= '0;
            end

            // Dropping dbg_req abandons an ungranted request, so the
            // starvation history is forgotten as well.
            if (w_dbg_grant || !dbg_req) begin
                r_wait_cnt <= '0;
            end else if (w_dbg_elig && w_if_grant && !w_wait_full) begin
                r_wait_cnt <= r_wait_cnt + WCW'(1);
            end
        end
    end

    assign if_inst  = r_if_inst;
    assign if_valid = r_if_valid;
    assign dbg_inst = r_dbg_inst;
    assign dbg_ack  = r_dbg_ack;
    assign dbg_err  = r_dbg_err;

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
// tb/tb_inst_fetch_arbiter.sv - scoreboard testbench for inst_fetch_arbiter

module tb_inst_fetch_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dbg_req;
    logic [31:0] dbg_addr;

    logic [31:0] if_inst4, dbg_inst4, rom_addr4, rom_inst4;
    logic        if_valid4, stall4, dbg_ack4, dbg_err4, rom_ce4;
    logic [31:0] if_inst0, dbg_inst0, rom_addr0, rom_inst0;
    logic        if_valid0, stall0, dbg_ack0, dbg_err0, rom_ce0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t if_q[$];
    exp_t dbg_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h34011100;
            32'h4:   return 32'h34020020;
            32'h8:   return 32'h3403FF00;
            32'h10:  return 32'h00221825;
            default: return 32'hDEAD0000 ^ a;
        endcase
    endfunction

    assign rom_inst4 = rom_word(rom_addr4);
    assign rom_inst0 = rom_word(rom_addr0);

    inst_fetch_arbiter #(.MAX_WAIT(4)) dut4 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst4),
        .if_valid(if_valid4), .stall_req(stall4),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_inst(dbg_inst4),
        .dbg_ack(dbg_ack4), .dbg_err(dbg_err4),
        .rom_ce(rom_ce4), .rom_addr(rom_addr4), .rom_inst(rom_inst4)
    );

    inst_fetch_arbiter #(.MAX_WAIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst0),
        .if_valid(if_valid0), .stall_req(stall0),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_inst(dbg_inst0),
        .dbg_ack(dbg_ack0), .dbg_err(dbg_err0),
        .rom_ce(rom_ce0), .rom_addr(rom_addr0), .rom_inst(rom_inst0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic push_if(input logic [31:0] d);
        exp_t e;
        e.cyc = cyc + 1; e.data = d; e.err = 1'b0;
        if_q.push_back(e);
    endtask

    task automatic push_dbg(input logic [31:0] d, input logic err);
        exp_t e;
        e.cyc = cyc + 1; e.data = d; e.err = err;
        dbg_q.push_back(e);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da);
        @(posedge clk);
        #1;
        if_req = ir; if_addr = ia; dbg_req = dr; dbg_addr = da;
    endtask

    task automatic comb4(input string tag, input logic ce, input logic [31:0] a, input logic st);
        #3;
        chk({tag, ".rom_ce"},    rom_ce4,   ce);
        chk({tag, ".rom_addr"},  rom_addr4, a);
        chk({tag, ".stall_req"}, stall4,    st);
    endtask

    // Monitor for the MAX_WAIT=4 instance: every expectation is due in an
    // exact cycle; any valid/ack without one is an error.
    always @(negedge clk) begin
        exp_t e;
        if (if_q.size() > 0 && if_q[0].cyc == cyc) begin
            e = if_q.pop_front();
            chk("if_valid", if_valid4, 1'b1);
            chk("if_inst",  if_inst4,  e.data);
        end else if (if_valid4) begin
            chk("if_unexpected", if_valid4, 1'b0);
        end
        if (dbg_q.size() > 0 && dbg_q[0].cyc == cyc) begin
            e = dbg_q.pop_front();
            chk("dbg_ack",  dbg_ack4,  1'b1);
            chk("dbg_inst", dbg_inst4, e.data);
            chk("dbg_err",  dbg_err4,  e.err);
        end else if (dbg_ack4 || dbg_err4) begin
            chk("dbg_unexpected_ack", dbg_ack4, 1'b0);
            chk("dbg_unexpected_err", dbg_err4, 1'b0);
        end
    end

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h4; dbg_req = 1'b1; dbg_addr = 32'h10;

        // Reset state with both requesters active.
        repeat (2) @(posedge clk);
        #4;
        chk("rst.rom_ce",   rom_ce4,   1'b0);
        chk("rst.rom_addr", rom_addr4, 32'h0);
        chk("rst.stall",    stall4,    1'b0);
        chk("rst.if_valid", if_valid4, 1'b0);
        chk("rst.if_inst",  if_inst4,  32'h0);
        chk("rst.dbg_ack",  dbg_ack4,  1'b0);
        chk("rst.dbg_err",  dbg_err4,  1'b0);
        chk("rst.dbg_inst", dbg_inst4, 32'h0);
        chk("rst0.rom_ce",  rom_ce0,   1'b0);
        chk("rst0.stall",   stall0,    1'b0);

        drive(1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b1;
        comb4("idle0", 1'b0, 32'h0, 1'b0);

        // Uncontended IF.
        drive(1'b1, 32'h0, 1'b0, 32'h0); push_if(32'h34011100); comb4("if0", 1'b1, 32'h0, 1'b0);
        drive(1'b1, 32'h4, 1'b0, 32'h0); push_if(32'h34020020); comb4("if1", 1'b1, 32'h4, 1'b0);
        drive(1'b1, 32'h8, 1'b0, 32'h0); push_if(32'h3403FF00); comb4("if2", 1'b1, 32'h8, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0); comb4("idle1", 1'b0, 32'h0, 1'b0);

        // Idle DBG read; request drops in the ack cycle.
        drive(1'b0, 32'h0, 1'b1, 32'h10); push_dbg(32'h00221825, 1'b0);
        comb4("dbg", 1'b1, 32'h10, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h10); comb4("idle2", 1'b0, 32'h0, 1'b0);

        // Starvation: DBG wins at k=4 and again at k=10 (ack gap at k=5).
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 32'h8, 1'b1, 32'h10);
            if (k == 4 || k == 10) begin
                push_dbg(32'h00221825, 1'b0);
                comb4("starve_dbg", 1'b1, 32'h10, 1'b1);
            end else begin
                push_if(32'h3403FF00);
                comb4("starve_if", 1'b1, 32'h8, 1'b0);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0); comb4("idle3", 1'b0, 32'h0, 1'b0);

        // Misaligned DBG alongside IF.
        drive(1'b1, 32'h4, 1'b1, 32'h6);
        push_if(32'h34020020); push_dbg(32'h0, 1'b1);
        comb4("misal", 1'b1, 32'h4, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0); comb4("idle4", 1'b0, 32'h0, 1'b0);

        // Reset in the cycle DBG is granted after 4 denials.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h0, 1'b1, 32'h10); push_if(32'h34011100);
            comb4("prerst_if", 1'b1, 32'h0, 1'b0);
        end
        drive(1'b1, 32'h0, 1'b1, 32'h10);
        comb4("prerst_dbg", 1'b1, 32'h10, 1'b1);
        #2 rst = 1'b0;
        @(posedge clk);
        #4;
        chk("midrst.dbg_ack",  dbg_ack4,  1'b0);
        chk("midrst.if_valid", if_valid4, 1'b0);
        chk("midrst.dbg_inst", dbg_inst4, 32'h0);
        chk("midrst.if_inst",  if_inst4,  32'h0);
        chk("midrst.rom_ce",   rom_ce4,   1'b0);
        chk("midrst.stall",    stall4,    1'b0);

        // After release wait_cnt must start from 0: four IF grants first.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h0, 1'b1, 32'h10);
            rst = 1'b1;
            if (k == 4) begin
                push_dbg(32'h00221825, 1'b0);
                comb4("postrst_dbg", 1'b1, 32'h10, 1'b1);
            end else begin
                push_if(32'h34011100);
                comb4("postrst_if", 1'b1, 32'h0, 1'b0);
            end
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0); comb4("idle5", 1'b0, 32'h0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'h0); comb4("idle6", 1'b0, 32'h0, 1'b0);

        // MAX_WAIT=0 instance: DBG first, IF in the ack cycle, DBG again.
        drive(1'b1, 32'h8, 1'b1, 32'h10); push_if(32'h3403FF00);
        #3;
        chk("mw0.k0.rom_addr", rom_addr0, 32'h10);
        chk("mw0.k0.stall",    stall0,    1'b1);
        drive(1'b1, 32'h8, 1'b1, 32'h10); push_if(32'h3403FF00);
        #3;
        chk("mw0.k1.dbg_ack",  dbg_ack0,  1'b1);
        chk("mw0.k1.dbg_inst", dbg_inst0, 32'h00221825);
        chk("mw0.k1.rom_addr", rom_addr0, 32'h8);
        chk("mw0.k1.stall",    stall0,    1'b0);
        drive(1'b1, 32'h8, 1'b1, 32'h10); push_if(32'h3403FF00);
        #3;
        chk("mw0.k2.if_valid", if_valid0, 1'b1);
        chk("mw0.k2.if_inst",  if_inst0,  32'h3403FF00);
        chk("mw0.k2.dbg_ack",  dbg_ack0,  1'b0);
        chk("mw0.k2.stall",    stall0,    1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        chk("mw0.k3.dbg_ack",  dbg_ack0,  1'b1);
        chk("mw0.k3.if_valid", if_valid0, 1'b0);
        chk("mw0.k3.stall",    stall0,    1'b0);

        repeat (3) @(posedge clk);
        #6;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch_arbiter.md
# inst_fetch_arbiter

Shares the single combinational instruction ROM between the pipeline fetch stage (IF) and a debug/trace read port (DBG). IF has priority. A starvation counter guarantees DBG a slot after a bounded wait. The selected access is registered, so each requester receives data one cycle after grant. The block sits between `pc_reg`/`if_id`, the debug unit and `inst_rom`, and raises a stall request to `ctrl` whenever it takes the ROM away from a requesting IF.

## Interface
Parameters:
- `MAX_WAIT`, default 4: consecutive denied cycles DBG tolerates before it preempts IF. 0 means DBG always wins.

Ports:
- `clk`  in  1  — sole clock; all state updates on rising edge.
- `rst`  in  1  — synchronous reset, active-low (0 = reset).
- `if_req`  in  1  — IF fetch request, level.
- `if_addr`  in  `InstAddrBus`  — IF byte address.
- `if_inst`  out  `InstBus`  — registered IF instruction.
- `if_valid`  out  1  — `if_inst` valid this cycle.
- `stall_req`  out  1  — combinational; high when `if_req` is high and DBG holds the grant this cycle.
- `dbg_req`  in  1  — DBG read request, level, held until `dbg_ack`.
- `dbg_addr`  in  `InstAddrBus`  — DBG byte address, stable while `dbg_req` is high.
- `dbg_inst`  out  `InstBus`  — registered DBG read data.
- `dbg_ack`  out  1  — one-cycle completion pulse.
- `dbg_err`  out  1  — qualifies `dbg_ack`: misaligned address, no ROM access.
- `rom_ce`  out  1  — to `inst_rom` ce; `ChipEnable`/`ChipDisable`.
- `rom_addr`  out  `InstAddrBus`  — to `inst_rom` addr.
- `rom_inst`  in  `InstBus`  — from `inst_rom`, combinational.

## Operation
- **DBG eligibility.** DBG is eligible when `dbg_req`=1, `dbg_ack` is not high this cycle, and `dbg_addr[1:0]`=0.
- **Grant (combinational, per cycle).**
  - DBG wins if eligible and (`if_req`=0 or `wait_cnt` >= `MAX_WAIT`).
  - Otherwise IF wins if `if_req`=1.
  - Otherwise there is no grant.
- **ROM drive.**
  - Winner drives `rom_addr`; `rom_ce`=`ChipEnable`.
  - With no winner: `rom_ce`=`ChipDisable`, `rom_addr`=`ZeroWord`.
- **wait_cnt.**
  - Width $clog2(`MAX_WAIT`+1), saturating.
  - Cleared when DBG is granted, `dbg_req`=0, or on reset.
  - Incremented when DBG is eligible but IF wins.
- **Misaligned DBG** (`dbg_req`=1, `dbg_addr[1:0]`≠0, `dbg_ack` low):
  - No ROM access and not treated as a grant; IF proceeds unaffected in the same cycle.
  - Next cycle: `dbg_ack`=1, `dbg_err`=1, `dbg_inst`=`ZeroWord`.
- **IF addresses** are passed through unchecked; the ROM ignores the low bits.
- **Single outstanding DBG access.** In the `dbg_ack` cycle DBG is not eligible, so a held `dbg_req` yields at most one access every 2 cycles. IF may be granted every cycle.
- **stall_req** = `if_req` AND DBG granted. It is never asserted during reset.

## Timing
- **Latency.** Grant in cycle N. `rom_inst` is captured at the end of N. The winner's data and valid/ack are high in N+1 for exactly one cycle.
- **IF throughput** is 1 per cycle when uncontended. `if_valid` is low in N+1 if IF was not granted in N; `if_inst` holds its last value.
- **DBG.** `dbg_ack` and `dbg_err` are 0 except in the ack cycle. `dbg_inst` holds its value after the ack.
- **Reset** (`rst`=0 at an edge) sets: `if_inst`=`dbg_inst`=`ZeroWord`, `if_valid`=`dbg_ack`=`dbg_err`=0, `wait_cnt`=0.
- **Combinational outputs while `rst`=0:** `rom_ce`=`ChipDisable`, `rom_addr`=`ZeroWord`, `stall_req`=0.
- **Reset mid-access:** a grant made in the cycle before reset produces no valid/ack.
- **DBG drops `dbg_req` early:** an ack already scheduled still fires. An ungranted request is abandoned and `wait_cnt` clears.

## Test plan
- **Uncontended IF.** Stimulus: `if_req`=1, addr 0x0, 0x4, 0x8 on consecutive cycles, ROM words 0x34011100/0x34020020/0x3403FF00. Response: `if_valid`=1 and matching `if_inst` on the 3 following cycles; `stall_req`=0 throughout.
- **Idle DBG read.** Stimulus: `if_req`=0, `dbg_req`=1, addr 0x10, ROM word 0x00221825. Response: `rom_ce` enabled with `rom_addr`=0x10 that cycle; next cycle `dbg_ack`=1, `dbg_inst`=0x00221825, `dbg_err`=0.
- **Starvation, `MAX_WAIT`=4.** Stimulus: `if_req` and `dbg_req` both held high. Response:
  - IF is granted 4 cycles (`wait_cnt` 0→4) and DBG is granted on the 5th with `stall_req`=1 in that cycle only.
  - `dbg_ack` follows; IF is regranted the next cycle.
  - The pattern repeats every 5 grants plus the ack gap.
- **Misaligned DBG with IF.** Stimulus: `dbg_addr`=0x6 and `if_req`=1 in the same cycle. Response: IF is granted with no stall; next cycle `if_valid`=1 and `dbg_ack`=`dbg_err`=1, `dbg_inst`=0.
- **Reset mid-access.** Stimulus: DBG granted in cycle N, `rst`=0 at the end of N. Response: no `dbg_ack` in N+1; all outputs at reset values; `wait_cnt`=0 after release.
- **`MAX_WAIT`=0.** Stimulus: `if_req`=`dbg_req`=1. Response: DBG is granted immediately; `stall_req`=1 in the grant cycle, then `stall_req`=0 and IF is granted in the ack cycle.
